image_capture_sequencer: RTL and testbench

Sequences single-frame captures from a parallel image sensor bus running in the sensor's `pixclk` domain. After a software arm, it waits for a clean frame boundary and skips the leading blanking pixels of each line. It then streams pixels as linear write strobes into a frame buffer and reports completion and geometry errors. It sits between the sensor pad interface (the `reader` view: data, hsync, vsync) and the frame-buffer write port.

---
 rtl/image_capture_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 35 +++
 rtl/image_capture_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_image_capture_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_capture_pkg.sv
// Shared types and constants for the image capture sequencer.
package image_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_VS,
        CAPTURE,
        DONE
    } capture_state_t;

    localparam int ROWS_W = 16;

    // Line counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ROWS_W-1:0] sat_inc_rows(input logic [ROWS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Input stage for sensor sync lines: one register stage (S), a copy of the
// previous S, and per-bit rise/fall pulses derived from S versus previous S.
module sync_edge_detect #(
    parameter int N = 2
) (
    input  logic         pixclk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] s,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] s_reg;
    logic [N-1:0] prev_reg;

    // Sample the pad signals, then keep one cycle of history for edges.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg    <= '0;
            prev_reg <= '0;
        end else begin
            s_reg    <= din;
            prev_reg <= s_reg;
        end
    end

    assign s = s_reg;

    for (genvar gi = 0; gi < N; gi++) begin : g_edge
        assign rise[gi] = s_reg[gi] & ~prev_reg[gi];
        assign fall[gi] = ~s_reg[gi] & prev_reg[gi];
    end

endmodule

// File: rtl/image_capture_sequencer.sv
// Single-frame capture sequencer for a parallel sensor bus. Arms on request,
// waits for a clean frame start, skips HSKIP pixels per line and streams the
// remaining in-window pixels to a linear frame-buffer write port.
// Optional crop window: define IMAGE_CAPTURE_CROP_EN.
module image_capture_sequencer
    import image_capture_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_COLS = 640,
    parameter int MAX_ROWS = 480,
    parameter int HSKIP    = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              arm,
    input  logic              abort,
`ifdef IMAGE_CAPTURE_CROP_EN
    input  logic [15:0]       crop_x0,
    input  logic [15:0]       crop_y0,
    input  logic [15:0]       crop_w,
    input  logic [15:0]       crop_h,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [ROWS_W-1:0] rows_seen
);

    localparam int LINE_PIX = HSKIP + MAX_COLS;
    localparam int COL_W    = $clog2(LINE_PIX + 2);
    localparam int TOTAL    = MAX_COLS * MAX_ROWS;

    capture_state_t    state_reg;
    logic              busy_reg, done_reg, err_reg, wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W:0]   addr_cnt_reg;   // extra bit so the stop point never aliases to 0
    logic [WIDTH-1:0]  wr_data_reg;
    logic [WIDTH-1:0]  data_s_reg;
    logic [ROWS_W-1:0] rows_seen_reg;
    logic [COL_W-1:0]  col_cnt_reg;
`ifdef IMAGE_CAPTURE_CROP_EN
    logic [15:0]       x0_reg, y0_reg, w_reg, h_reg;
`endif

    logic [1:0] sync_s, sync_rise, sync_fall;
    logic       hsync_s, vsync_s, hsync_rise, hsync_fall, vsync_rise, vsync_fall;

    sync_edge_detect #(.N(2)) u_sync (
        .pixclk (pixclk),
        .rst_n  (rst_n),
        .din    ({vsync, hsync}),
        .s      (sync_s),
        .rise   (sync_rise),
        .fall   (sync_fall)
    );

    assign hsync_s    = sync_s[0];
    assign vsync_s    = sync_s[1];
    assign hsync_rise = sync_rise[0];
    assign hsync_fall = sync_fall[0];
    assign vsync_rise = sync_rise[1];
    assign vsync_fall = sync_fall[1];

    // Pixel data takes the same single register stage as the sync lines.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) data_s_reg <= '0;
        else        data_s_reg <= data;
    end

    logic [COL_W-1:0]  pix_idx, col_next;
    logic [ROWS_W-1:0] rows_new;
    int                col_i, row_i;
    logic              wr_ok, err_set;

    // Per-pixel decode: position within line/frame, write decision, error causes.
    always_comb begin
        pix_idx  = hsync_rise ? '0 : col_cnt_reg;
        rows_new = hsync_rise ? sat_inc_rows(rows_seen_reg) : rows_seen_reg;
        col_i    = int'(pix_idx) - HSKIP;
        row_i    = int'(rows_new) - 1;
        wr_ok    = hsync_s && (col_i >= 0) && (col_i < MAX_COLS) &&
                   (row_i >= 0) && (row_i < MAX_ROWS) && (int'(addr_cnt_reg) < TOTAL);
`ifdef IMAGE_CAPTURE_CROP_EN
        wr_ok    = wr_ok &&
                   (col_i >= int'(x0_reg)) && (col_i < int'(x0_reg) + int'(w_reg)) &&
                   (row_i >= int'(y0_reg)) && (row_i < int'(y0_reg) + int'(h_reg));
`endif
        if (!hsync_s)      col_next = col_cnt_reg;
        else if (&pix_idx) col_next = pix_idx;
        else               col_next = pix_idx + 1'b1;
        err_set  = (hsync_s && int'(pix_idx) >= LINE_PIX) ||
                   (hsync_rise && int'(rows_seen_reg) >= MAX_ROWS) ||
                   (hsync_fall && int'(col_cnt_reg) < LINE_PIX) ||
                   (vsync_fall && hsync_s);
    end

    // Capture FSM with all outputs registered; abort overrides everything outside IDLE.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            addr_cnt_reg  <= '0;
            wr_data_reg   <= '0;
            rows_seen_reg <= '0;
            col_cnt_reg   <= '0;
`ifdef IMAGE_CAPTURE_CROP_EN
            x0_reg        <= '0;
            y0_reg        <= '0;
            w_reg         <= '0;
            h_reg         <= '0;
`endif
        end else begin
            done_reg  <= 1'b0;
            wr_en_reg <= 1'b0;
            if (abort && state_reg != IDLE) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        if (arm && !abort) begin
                            state_reg     <= SYNC;
                            busy_reg      <= 1'b1;
                            err_reg       <= 1'b0;
                            rows_seen_reg <= '0;
                            addr_cnt_reg  <= '0;
                            wr_addr_reg   <= '0;
                            col_cnt_reg   <= '0;
`ifdef IMAGE_CAPTURE_CROP_EN
                            x0_reg        <= crop_x0;
                            y0_reg        <= crop_y0;
                            w_reg         <= crop_w;
                            h_reg         <= crop_h;
`endif
                        end
                    end
                    SYNC: begin
                        if (!vsync_s) state_reg <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (vsync_rise) begin
                            state_reg   <= CAPTURE;
                            col_cnt_reg <= '0;
                        end
                    end
                    CAPTURE: begin
                        rows_seen_reg <= rows_new;
                        col_cnt_reg   <= col_next;
                        if (wr_ok) begin
                            wr_en_reg    <= 1'b1;
                            wr_data_reg  <= data_s_reg;
                            wr_addr_reg  <= addr_cnt_reg[ADDR_W-1:0];
                            addr_cnt_reg <= addr_cnt_reg + 1'b1;
                        end
                        if (err_set) err_reg <= 1'b1;
                        if (vsync_fall) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign rows_seen = rows_seen_reg;

endmodule

// File: tb/tb_image_capture_sequencer.sv
// Self-checking bench for image_capture_sequencer (small geometry: 4x3, HSKIP=1).
// Frames are described as line lengths plus pixel values; the expected write
// stream is derived from the capture rules and compared with what the DUT wrote.
module tb_image_capture_sequencer;

    localparam int WD = 8;
    localparam int MC = 4;
    localparam int MR = 3;
    localparam int HS = 1;
    localparam int AW = 8;

    logic          pixclk, rst_n;
    logic [WD-1:0] data;
    logic          hsync, vsync, arm, abort;
    logic          busy, done, err, wr_en;
    logic [AW-1:0] wr_addr;
    logic [WD-1:0] wr_data;
    logic [15:0]   rows_seen;
`ifdef IMAGE_CAPTURE_CROP_EN
    logic [15:0]   crop_x0, crop_y0, crop_w, crop_h;
`endif

    image_capture_sequencer #(
        .WIDTH(WD), .MAX_COLS(MC), .MAX_ROWS(MR), .HSKIP(HS), .ADDR_W(AW)
    ) dut (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .data      (data),
        .hsync     (hsync),
        .vsync     (vsync),
        .arm       (arm),
        .abort     (abort),
`ifdef IMAGE_CAPTURE_CROP_EN
        .crop_x0   (crop_x0),
        .crop_y0   (crop_y0),
        .crop_w    (crop_w),
        .crop_h    (crop_h),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rows_seen (rows_seen)
    );

    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Frame description and expected results
    int            line_len [0:7];
    logic [WD-1:0] pix [0:7][0:7];
    int            cur_nl;
    logic [WD-1:0] exp_q [$];
    int            exp_err, exp_rows;
    int            cx0 = 0, cy0 = 0, cw = MC, ch = MR;

    // Observed write stream
    logic [AW-1:0] obs_addr [$];
    logic [WD-1:0] obs_data [$];
    int            done_cnt = 0;
    int            cyc = 0, last_wr_cyc = 0, done_cyc = 0;

    always @(posedge pixclk) cyc = cyc + 1;

    always @(negedge pixclk) begin
        if (wr_en === 1'b1) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic gen_frame(input int nl, input bit rand_len);
        cur_nl = nl;
        for (int l = 0; l < nl; l++) begin
            if (rand_len && $urandom_range(0, 1) == 1) line_len[l] = $urandom_range(1, 7);
            else                                        line_len[l] = HS + MC;
            for (int p = 0; p < 8; p++) pix[l][p] = WD'($urandom_range(0, 255));
        end
    endtask

    // Expected writes: after HSKIP, columns < MAX_COLS of lines < MAX_ROWS inside
    // the crop window, in raster order; addresses are positions in that list.
    task automatic build_expected();
        exp_q.delete();
        exp_err  = (cur_nl > MR) ? 1 : 0;
        exp_rows = cur_nl;
        for (int l = 0; l < cur_nl; l++) begin
            if (line_len[l] != HS + MC) exp_err = 1;
            for (int p = HS; p < line_len[l]; p++) begin
                int c;
                c = p - HS;
                if (c < MC && l < MR && c >= cx0 && c < cx0 + cw && l >= cy0 && l < cy0 + ch)
                    exp_q.push_back(pix[l][p]);
            end
        end
    endtask

    task automatic do_arm();
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0;
        arm = 1'b1;
        @(negedge pixclk);
        arm = 1'b0;
    endtask

    task automatic drive_line(input int l);
        for (int p = 0; p < line_len[l]; p++) begin
            hsync = 1'b1;
            data  = pix[l][p];
            @(negedge pixclk);
        end
        hsync = 1'b0;
        data  = '0;
        repeat (2) @(negedge pixclk);
    endtask

    task automatic drive_frame();
        vsync = 1'b0;
        repeat (3) @(negedge pixclk);
        vsync = 1'b1;
        repeat (2) @(negedge pixclk);
        for (int l = 0; l < cur_nl; l++) drive_line(l);
        vsync = 1'b0;
        repeat (8) @(negedge pixclk);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, ".nwr"}, obs_addr.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_addr.size(); i++) begin
            check({tag, ".addr"}, obs_addr[i], i);
            check({tag, ".data"}, obs_data[i], exp_q[i]);
        end
        check({tag, ".done"}, done_cnt, 1);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".rows"}, rows_seen, exp_rows);
        check({tag, ".busy"}, busy, 0);
        if (exp_q.size() > 0) check({tag, ".done_after_wr"}, 32'(done_cyc > last_wr_cyc), 1);
        $display("frame %s lines=%0d writes=%0d/%0d err=%0b rows=%0d", tag, cur_nl,
                 obs_addr.size(), exp_q.size(), err, rows_seen);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".wr_en"}, wr_en, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".rows"}, rows_seen, 0);
    endtask

    initial begin
        int snap;
        rst_n = 1'b0; data = '0; hsync = 1'b0; vsync = 1'b0; arm = 1'b0; abort = 1'b0;
`ifdef IMAGE_CAPTURE_CROP_EN
        crop_x0 = 16'd0; crop_y0 = 16'd0; crop_w = 16'(MC); crop_h = 16'(MR);
`endif
        repeat (3) @(negedge pixclk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge pixclk);

        // Directed frame: 3 lines of 5 pixels, values 0x10..0x1E
        cur_nl = 3;
        for (int l = 0; l < 3; l++) begin
            line_len[l] = 5;
            for (int p = 0; p < 5; p++) pix[l][p] = WD'(8'h10 + 5 * l + p);
        end
        build_expected();
        do_arm();
        drive_frame();
        compare_frame("basic");

        // Arm in the middle of a frame: that frame must be ignored entirely
        vsync = 1'b1;
        gen_frame(3, 1'b0);
        repeat (2) @(negedge pixclk);
        drive_line(0);
        do_arm();
        drive_line(1);
        drive_line(2);
        gen_frame(3, 1'b0);
        build_expected();
        drive_frame();
        compare_frame("midarm");

        // Four lines, one 7-pixel line: writes limited to 12, error flagged
        gen_frame(4, 1'b0);
        line_len[1] = 7;
        build_expected();
        do_arm();
        drive_frame();
        compare_frame("oversize");

        // Random geometries
        for (int f = 0; f < 5; f++) begin
            gen_frame($urandom_range(1, 5), 1'b1);
            build_expected();
            do_arm();
            drive_frame();
            compare_frame($sformatf("rand%0d", f));
        end

        // Abort during the second line
        gen_frame(3, 1'b0);
        do_arm();
        vsync = 1'b0;
        repeat (3) @(negedge pixclk);
        vsync = 1'b1;
        repeat (2) @(negedge pixclk);
        drive_line(0);
        hsync = 1'b1; data = pix[1][0];
        @(negedge pixclk);
        data = pix[1][1]; abort = 1'b1;
        @(negedge pixclk);
        abort = 1'b0;
        check("abort.busy", busy, 0);
        snap = obs_addr.size();
        for (int p = 2; p < line_len[1]; p++) begin
            data = pix[1][p];
            @(negedge pixclk);
        end
        hsync = 1'b0;
        repeat (2) @(negedge pixclk);
        drive_line(2);
        vsync = 1'b0;
        repeat (8) @(negedge pixclk);
        check("abort.no_more_wr", obs_addr.size(), snap);
        check("abort.no_done", done_cnt, 0);
        $display("abort writes_before=%0d busy=%0b", snap, busy);

        // Reset in the middle of a frame, then re-arm
        gen_frame(3, 1'b0);
        do_arm();
        vsync = 1'b0;
        repeat (3) @(negedge pixclk);
        vsync = 1'b1;
        repeat (2) @(negedge pixclk);
        drive_line(0);
        hsync = 1'b1; data = pix[1][0];
        repeat (2) @(negedge pixclk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge pixclk);
        rst_n = 1'b1;
        hsync = 1'b0; data = '0;
        repeat (2) @(negedge pixclk);
        arm = 1'b1; abort = 1'b1;
        @(negedge pixclk);
        arm = 1'b0; abort = 1'b0;
        @(negedge pixclk);
        check("arm_abort.busy", busy, 0);
        $display("arm+abort in idle busy=%0b", busy);
        do_arm();
        drive_line(2);
        gen_frame(3, 1'b0);
        build_expected();
        drive_frame();
        compare_frame("rearm");

`ifdef IMAGE_CAPTURE_CROP_EN
        // Crop window 2x2 starting at column 1, line 1
        crop_x0 = 16'd1; crop_y0 = 16'd1; crop_w = 16'd2; crop_h = 16'd2;
        cx0 = 1; cy0 = 1; cw = 2; ch = 2;
        gen_frame(3, 1'b0);
        build_expected();
        do_arm();
        crop_x0 = 16'd0; crop_y0 = 16'd0; crop_w = 16'(MC); crop_h = 16'(MR);
        drive_frame();
        compare_frame("crop");
        cx0 = 0; cy0 = 0; cw = MC; ch = MR;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
